// File: rtl/aes_key_sched_ctrl_if.sv
// Round-key stream between the key-schedule sequencer and the cipher round core.
//   master : sequencer side (drives rk_valid, rk_data, rk_idx; samples rk_ready)
//   slave  : cipher core side (samples the key; drives rk_ready)
interface aes_key_sched_ctrl_if #(
   parameter int KW = 128
);
   logic          rk_valid;
   logic          rk_ready;
   logic [KW-1:0] rk_data;
   logic [3:0]    rk_idx;

   modport master (
      output rk_valid,
      output rk_data,
      output rk_idx,
      input  rk_ready
   );

   modport slave (
      input  rk_valid,
      input  rk_data,
      input  rk_idx,
      output rk_ready
   );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for the iterative AES-128 key expander. Captures a cipher key on an
// accepted start, strobes the expander (kx_load once, then kx_next per accepted
// round key) and streams round keys 0..NR to the cipher core with no bubbles
// while rk_ready stays high.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, key_in     begin a sequence (IDLE only), key sampled on accept
//   reuse_key         replay cached round keys (only with KEY_CACHE_EN)
//   abort             cancel an in-progress sequence
//   busy, done        status; done is a one-cycle pulse after key NR
//   seq_err           sticky expander/sequencer round mismatch
//   kx_load, kx_next  expander strobes; kx_key_in key presented to expander
//   kx_key_out        expander current round key; kx_round its round index
//   rk                round-key stream (master modport)
//
// Build option: define KEY_CACHE_EN to add an (NR+1)-entry round-key cache
// that can be replayed without re-running the expander.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// LOAD   | kx_load high for one cycle, expander latches the key
// STREAM | round key rnd offered on rk; advances on each handshake
// DONE   | done pulse after key NR accepted, back to IDLE
module aes_key_sched_ctrl #(
   parameter int NR = 10,
   parameter int KW = 128
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [KW-1:0]        key_in,
   input  logic                 reuse_key,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 seq_err,
   output logic                 kx_load,
   output logic                 kx_next,
   output logic [KW-1:0]        kx_key_in,
   input  logic [KW-1:0]        kx_key_out,
   input  logic [3:0]           kx_round,
   aes_key_sched_ctrl_if.master rk
);

   localparam logic [3:0] LAST = 4'(NR);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_STREAM,
      S_DONE
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] rnd;
   logic       rk_valid_c;
   logic       start_acc;
   logic       start_reuse;
   logic       hs;
   logic       from_cache;
   logic       cache_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      busy        = 1'b1;
      done        = 1'b0;
      kx_load     = 1'b0;
      kx_next     = 1'b0;
      rk_valid_c  = 1'b0;
      start_acc   = 1'b0;
      start_reuse = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               start_acc   = 1'b1;
               start_reuse = reuse_key & cache_vld;
               state_d     = start_reuse ? S_STREAM : S_LOAD;
            end
         end
         S_LOAD: begin
            kx_load = 1'b1;
            state_d = abort ? S_IDLE : S_STREAM;
         end
         S_STREAM: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               rk_valid_c = 1'b1;
               if (rk.rk_ready) begin
                  if (rnd == LAST) begin
                     state_d = S_DONE;
                  end else begin
                     // The expander only advances when it is the key source.
                     kx_next = ~from_cache;
                  end
               end
            end
         end
         S_DONE: begin
            done    = ~abort;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign hs = rk_valid_c & rk.rk_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         rnd       <= '0;
         kx_key_in <= '0;
         seq_err   <= 1'b0;
      end else if (start_acc) begin
         rnd       <= '0;
         kx_key_in <= key_in;
         seq_err   <= 1'b0;
      end else begin
         if (hs && (rnd != LAST)) begin
            rnd <= rnd + 4'd1;
         end
         // Cached replay leaves the expander idle, so its round index is stale.
         if ((state_q == S_STREAM) && !from_cache && (kx_round != rnd)) begin
            seq_err <= 1'b1;
         end
      end
   end

`ifdef KEY_CACHE_EN
   logic [KW-1:0] cache [NR+1];
   logic          from_cache_q;
   logic          cache_vld_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         from_cache_q <= 1'b0;
         cache_vld_q  <= 1'b0;
      end else if (start_acc) begin
         from_cache_q <= start_reuse;
         if (!start_reuse) begin
            cache_vld_q <= 1'b0;
         end
      end else if (!from_cache_q) begin
         // A cancelled expansion leaves a partially overwritten cache.
         if (abort && (state_q != S_IDLE)) begin
            cache_vld_q <= 1'b0;
         end else if (hs && (rnd == LAST)) begin
            cache_vld_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (hs && !from_cache_q) begin
         cache[rnd] <= kx_key_out;
      end
   end

   assign from_cache = from_cache_q;
   assign cache_vld  = cache_vld_q;
   assign rk.rk_data = from_cache_q ? cache[rnd] : kx_key_out;
`else
   assign from_cache = 1'b0;
   assign cache_vld  = 1'b0;
   assign rk.rk_data = kx_key_out;
`endif

   assign rk.rk_valid = rk_valid_c;
   assign rk.rk_idx   = rnd;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl with a behavioural key-expander model
// holding the FIPS-197 round keys of the reference key, and a scoreboard of
// expected (index, round key) pairs consumed on each rk handshake.
module tb_aes_key_sched_ctrl;
   localparam int KW = 128;
   localparam logic [KW-1:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [KW-1:0] KEY2 = 128'hdeadbeef0123456789abcdeffeedface;

   typedef struct {
      logic [3:0]    idx;
      logic [KW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [KW-1:0] key_in;
   logic          reuse_key;
   logic          abort;
   logic          busy;
   logic          done;
   logic          seq_err;
   logic          kx_load;
   logic          kx_next;
   logic [KW-1:0] kx_key_in;
   logic [KW-1:0] kx_key_out;
   logic [3:0]    kx_round;
   logic [3:0]    m_round;
   logic          force_en;
   logic [3:0]    force_val;

   logic [KW-1:0] rk_tab [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   exp_t exp_q [$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   n_next  = 0;
   int   n_load  = 0;
   int   n_done  = 0;
   int   cyc     = 0;
   int   t0      = 0;

   aes_key_sched_ctrl_if #(.KW(KW)) rk_if ();

   aes_key_sched_ctrl #(.NR(10), .KW(KW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key_in     (key_in),
      .reuse_key  (reuse_key),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .seq_err    (seq_err),
      .kx_load    (kx_load),
      .kx_next    (kx_next),
      .kx_key_in  (kx_key_in),
      .kx_key_out (kx_key_out),
      .kx_round   (kx_round),
      .rk         (rk_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expander model: round 0 after load, one round per kx_next.
   always @(posedge clk) begin
      if (rst) begin
         m_round <= 4'd0;
      end else if (kx_load) begin
         m_round <= 4'd0;
      end else if (kx_next && (m_round < 4'd10)) begin
         m_round <= m_round + 4'd1;
      end
   end
   assign kx_round   = force_en ? force_val : m_round;
   assign kx_key_out = rk_tab[m_round];

   task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Scoreboard / protocol monitor.
   always @(negedge clk) begin
      if (!rst) begin
         if (kx_load || kx_next) chk("load_next_exclusive", kx_load & kx_next, '0);
         if (kx_load) n_load++;
         if (kx_next) n_next++;
         if (done) n_done++;
         if (rk_if.rk_valid) begin
            if (exp_q.size() == 0) begin
               chk("rk_unexpected_valid", rk_if.rk_valid, '0);
            end else begin
               chk("rk_idx", rk_if.rk_idx, exp_q[0].idx);
               chk("rk_data", rk_if.rk_data, exp_q[0].data);
               if (rk_if.rk_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_seq(input logic [KW-1:0] key, input logic reuse);
      exp_t e;
      key_in    = key;
      reuse_key = reuse;
      start     = 1'b1;
      t0        = cyc;
      for (int i = 0; i <= 10; i++) begin
         e.idx  = 4'(i);
         e.data = rk_tab[i];
         exp_q.push_back(e);
      end
      n_next = 0;
      n_load = 0;
      n_done = 0;
      tick();
      start     = 1'b0;
      reuse_key = 1'b0;
      key_in    = '0;
   endtask

   task automatic wait_done(input int exp_k, input string tag);
      bit seen = 1'b0;
      int k_obs = 999;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (done) begin
            seen  = 1'b1;
            k_obs = cyc - t0;
         end
         tick();
      end
      chk(tag, k_obs, exp_k);
   endtask

   // Full expanding pass with rk_ready held high; called in cycle T+1.
   task automatic full_pass_checks(input string tag);
      @(negedge clk);
      chk({tag, "_kx_load_t1"}, kx_load, 1);
      chk({tag, "_valid_t1"}, rk_if.rk_valid, 0);
      chk({tag, "_kx_key_in"}, kx_key_in, KEY);
      tick();
      @(negedge clk);
      chk({tag, "_valid_t2"}, rk_if.rk_valid, 1);
      chk({tag, "_idx_t2"}, rk_if.rk_idx, 0);
      tick();
      wait_done(13, {tag, "_done_cycle"});
      @(negedge clk);
      chk({tag, "_busy_after"}, busy, 0);
      chk({tag, "_kx_next_cnt"}, n_next, 10);
      chk({tag, "_kx_load_cnt"}, n_load, 1);
      chk({tag, "_done_cnt"}, n_done, 1);
      chk({tag, "_queue_empty"}, exp_q.size(), 0);
      tick();
   endtask

   initial begin
      logic [3:0] pat;
      bit         seen;
      rst            = 1'b1;
      start          = 1'b0;
      reuse_key      = 1'b0;
      abort          = 1'b0;
      key_in         = '0;
      force_en       = 1'b0;
      force_val      = 4'd0;
      rk_if.rk_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_seq_err", seq_err, 0);
      chk("rst_kx_load", kx_load, 0);
      chk("rst_kx_next", kx_next, 0);
      chk("rst_rk_valid", rk_if.rk_valid, 0);
      chk("rst_kx_key_in", kx_key_in, 0);
      chk("rst_rk_idx", rk_if.rk_idx, 0);
      tick();

      // 1: straight expansion with ready high
      rk_if.rk_ready = 1'b1;
      start_seq(KEY, 1'b0);
      full_pass_checks("s1");
      chk("s1_seq_err", seq_err, 0);

      // 2: ready toggling 1,0,0,1
      pat = 4'b1001;
      seen = 1'b0;
      start_seq(KEY, 1'b0);
      for (int k = 0; k < 200 && !seen; k++) begin
         rk_if.rk_ready = pat[k[1:0]];
         @(negedge clk);
         if (done) seen = 1'b1;
         tick();
      end
      rk_if.rk_ready = 1'b1;
      chk("s2_done_seen", seen, 1);
      chk("s2_kx_next_cnt", n_next, 10);
      chk("s2_queue_empty", exp_q.size(), 0);
      chk("s2_seq_err", seq_err, 0);

      // 3: abort while key 4 is offered with ready high
      start_seq(KEY, 1'b0);
      repeat (5) tick();
      abort = 1'b1;
      @(negedge clk);
      chk("s3_idx_at_abort", rk_if.rk_idx, 4);
      chk("s3_valid_at_abort", rk_if.rk_valid, 0);
      chk("s3_next_at_abort", kx_next, 0);
      exp_q.delete();
      tick();
      abort = 1'b0;
      @(negedge clk);
      chk("s3_busy_after", busy, 0);
      chk("s3_valid_after", rk_if.rk_valid, 0);
      repeat (5) tick();
      chk("s3_no_done", n_done, 0);
      chk("s3_kx_next_cnt", n_next, 4);
      start_seq(KEY, 1'b0);
      full_pass_checks("s3r");

      // 4: start ignored while busy and during DONE
      start_seq(KEY, 1'b0);
      repeat (3) tick();
      start  = 1'b1;
      key_in = KEY2;
      @(negedge clk);
      chk("s4_busy", busy, 1);
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("s4_key_hold_busy", kx_key_in, KEY);
      repeat (8) tick();
      start  = 1'b1;
      key_in = KEY2;
      @(negedge clk);
      chk("s4_done_pulse", done, 1);
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("s4_idle_after", busy, 0);
      chk("s4_key_hold_done", kx_key_in, KEY);
      chk("s4_load_cnt", n_load, 1);
      chk("s4_done_cnt", n_done, 1);
      chk("s4_queue_empty", exp_q.size(), 0);
      tick();

      // 5: expander reports round 3 while rnd is 2
      start_seq(KEY, 1'b0);
      repeat (3) tick();
      force_val = 4'd3;
      force_en  = 1'b1;
      @(negedge clk);
      chk("s5_idx", rk_if.rk_idx, 2);
      chk("s5_seq_err_before", seq_err, 0);
      tick();
      force_en = 1'b0;
      @(negedge clk);
      chk("s5_seq_err_set", seq_err, 1);
      tick();
      wait_done(13, "s5_done_cycle");
      @(negedge clk);
      chk("s5_seq_err_sticky", seq_err, 1);
      tick();
      start_seq(KEY, 1'b0);
      @(negedge clk);
      chk("s5_seq_err_cleared", seq_err, 0);
      tick();
      wait_done(13, "s5b_done_cycle");
      chk("s5b_seq_err", seq_err, 0);

      // 6: reuse request after a completed expansion
      start_seq(KEY, 1'b1);
      @(negedge clk);
`ifdef KEY_CACHE_EN
      chk("s6_valid_t1", rk_if.rk_valid, 1);
      chk("s6_kx_load_t1", kx_load, 0);
      tick();
      wait_done(12, "s6_done_cycle");
      chk("s6_kx_load_cnt", n_load, 0);
      chk("s6_kx_next_cnt", n_next, 0);
      chk("s6_seq_err", seq_err, 0);
`else
      chk("s6_kx_load_t1", kx_load, 1);
      chk("s6_valid_t1", rk_if.rk_valid, 0);
      tick();
      wait_done(13, "s6_done_cycle");
      chk("s6_kx_load_cnt", n_load, 1);
      chk("s6_kx_next_cnt", n_next, 10);
`endif
      chk("s6_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
